spike_monitor: RTL

SPIKE_MONITOR -- requirements
Module: spike_monitor

---
 rtl/spike_monitor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/spike_monitor.sv
`default_nettype none
// ============================================================================
// spike_monitor : windowed spike statistics for a LIF neuron
//                 (spike count, minimum inter-spike interval, peak state)
// Revision      : 1.0
// ============================================================================
module spike_monitor #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         spike,
   input  logic [W-1:0] state_in,
   input  logic [W-1:0] win_len,
   input  logic         start,
   output logic         busy,
   output logic         result_valid,
   input  logic         result_ready,
   output logic [W-1:0] spike_count,
   output logic         sat,
   output logic [W-1:0] min_isi,
   output logic [W-1:0] peak_state
);

   localparam logic [1:0]   S_IDLE  = 2'd0;
   localparam logic [1:0]   S_COUNT = 2'd1;
   localparam logic [1:0]   S_HOLD  = 2'd2;
   localparam logic [W-1:0] C_ONES  = {W{1'b1}};
   localparam logic [W-1:0] C_ONE   = {{(W-1){1'b0}}, 1'b1};

   logic [1:0]   state_q,   state_d;
   logic [W-1:0] len_q,     len_d;
   logic [W-1:0] idx_q,     idx_d;
   logic [W-1:0] isi_q,     isi_d;
   logic         seen_q,    seen_d;
   logic [W-1:0] count_q,   count_d;
   logic         sat_q,     sat_d;
   logic [W-1:0] min_isi_q, min_isi_d;
   logic [W-1:0] peak_q,    peak_d;

   logic [W-1:0] isi_inc;
   logic [W-1:0] last_idx;

   always_comb begin
      // isi_q holds cycles elapsed since the previous spike; distance is one more
      isi_inc   = (isi_q == C_ONES) ? C_ONES : isi_q + C_ONE;
      // win_len of 0 wraps to all-ones here, giving a 2^W sample window
      last_idx  = len_q - C_ONE;
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      isi_d     = isi_q;
      seen_d    = seen_q;
      count_d   = count_q;
      sat_d     = sat_q;
      min_isi_d = min_isi_q;
      peak_d    = peak_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d     = win_len;
               idx_d     = '0;
               isi_d     = '0;
               seen_d    = 1'b0;
               count_d   = '0;
               sat_d     = 1'b0;
               min_isi_d = C_ONES;
               peak_d    = '0;
               state_d   = S_COUNT;
            end
         end
         S_COUNT: begin
            if (spike) begin
               if (count_q == C_ONES) begin
                  sat_d = 1'b1;
               end else begin
                  count_d = count_q + C_ONE;
               end
               if (seen_q && (isi_inc < min_isi_q)) begin
                  min_isi_d = isi_inc;
               end
               seen_d = 1'b1;
               isi_d  = '0;
            end else begin
               isi_d = isi_inc;
            end
            if (state_in > peak_q) begin
               peak_d = state_in;
            end
            idx_d = idx_q + C_ONE;
            if (idx_q == last_idx) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (result_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         isi_q     <= '0;
         seen_q    <= 1'b0;
         count_q   <= '0;
         sat_q     <= 1'b0;
         min_isi_q <= '0;
         peak_q    <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         isi_q     <= isi_d;
         seen_q    <= seen_d;
         count_q   <= count_d;
         sat_q     <= sat_d;
         min_isi_q <= min_isi_d;
         peak_q    <= peak_d;
      end
   end

   assign busy         = (state_q == S_COUNT) || (state_q == S_HOLD);
   assign result_valid = (state_q == S_HOLD);
   assign spike_count  = count_q;
   assign sat          = sat_q;
   assign min_isi      = min_isi_q;
   assign peak_state   = peak_q;

endmodule
`default_nettype wire
